// File: rtl/imm_load_sequencer.sv
// imm_load_sequencer: expands a 16-bit load-immediate into the shortest LI/SLL/ADDIU sequence
module imm_load_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_value,
    input  logic [2:0]  req_rx,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic        out_last,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_LI, S_SLL, S_ADDIU} state_t;
    typedef enum logic [1:0] {C_A, C_B, C_C, C_D} case_t;

    state_t      r_state, w_state_nxt;
    case_t       r_case, w_case_nxt, w_case_req;
    logic [15:0] r_val, w_val_nxt;
    logic [2:0]  r_rx, w_rx_nxt;
    logic [15:0] r_instr, w_instr_nxt;
    logic        r_valid, r_last, w_last_nxt;
    logic [7:0]  w_li_imm;

    always_comb
        w_case_req = (req_value[15:8] == 8'h00)   ? C_A :
                     (req_value[15:7] == 9'h1FF)  ? C_B :
                     (req_value[7:0] == 8'h00)    ? C_C : C_D;

    always_comb begin
        w_state_nxt = r_state;
        w_case_nxt  = r_case;
        w_val_nxt   = r_val;
        w_rx_nxt    = r_rx;
        case (r_state)
            S_IDLE: if (req_valid) begin
                w_state_nxt = S_LI;
                w_case_nxt  = w_case_req;
                w_val_nxt   = req_value;
                w_rx_nxt    = req_rx;
            end
            S_LI:    if (out_ready) w_state_nxt = (r_case == C_A) ? S_IDLE : (r_case == C_B) ? S_ADDIU : S_SLL;
            S_SLL:   if (out_ready) w_state_nxt = (r_case == C_C) ? S_IDLE : S_ADDIU;
            default: if (out_ready) w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they can be registered without a bubble
    always_comb begin
        w_li_imm = (w_case_nxt == C_A) ? w_val_nxt[7:0] :
                   (w_case_nxt == C_B) ? 8'h00 :
                   (w_case_nxt == C_C) ? w_val_nxt[15:8] :
                   w_val_nxt[15:8] + {7'b0, w_val_nxt[7]};
        w_instr_nxt = (w_state_nxt == S_LI)    ? {5'b01101, w_rx_nxt, w_li_imm} :
                      (w_state_nxt == S_SLL)   ? {5'b00110, w_rx_nxt, w_rx_nxt, 5'b00000} :
                      (w_state_nxt == S_ADDIU) ? {5'b01001, w_rx_nxt, w_val_nxt[7:0]} : 16'h0000;
        w_last_nxt = (w_state_nxt == S_LI && w_case_nxt == C_A) ||
                     (w_state_nxt == S_SLL && w_case_nxt == C_C) ||
                     (w_state_nxt == S_ADDIU);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_case  <= C_A;
            r_val   <= 16'h0000;
            r_rx    <= 3'd0;
            r_instr <= 16'h0000;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_case  <= w_case_nxt;
            r_val   <= w_val_nxt;
            r_rx    <= w_rx_nxt;
            r_instr <= w_instr_nxt;
            r_valid <= w_state_nxt != S_IDLE;
            r_last  <= w_last_nxt;
        end
    end

    assign req_ready = r_state == S_IDLE;
    assign busy      = r_state != S_IDLE;
    assign out_valid = r_valid;
    assign out_instr = r_instr;
    assign out_last  = r_last;
endmodule

// File: doc/imm_load_sequencer.md
# imm_load_sequencer

Expands a 16-bit load-immediate request into the shortest sequence of native 16-bit instructions (LI, SLL, ADDIU) whose decoded immediates rebuild the value in a target register. It is the encode-side counterpart of the decode-stage immediate extension: it emits only immediates that the decoder's zero-extend (LI), shift-amount (SLL, 0 means 8) and sign-extend (ADDIU) rules map back to the requested value. It sits between the pseudo-instruction source (boot loader or instruction injector) and the instruction-memory write / fetch-injection path, with valid/ready handshakes on both sides.

## Interface
- No parameters; the datapath is a fixed 16-bit width.
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer idle and accepting
- req_value  input  16  value to load
- req_rx  input  3  destination register index
- out_valid  output  1  out_instr holds a valid instruction
- out_ready  input  1  consumer accepts out_instr
- out_instr  output  16  encoded instruction
- out_last  output  1  out_instr is the final instruction of the sequence
- busy  output  1  sequence in progress; equals ~req_ready

## Operation
- Encodings, with rx = latched req_rx:
  - LI is {5'b01101, rx, imm8}.
  - SLL is {5'b00110, rx, rx, 3'b000, 2'b00}, meaning shift by 8.
  - ADDIU is {5'b01001, rx, imm8}.
- Notation: V = latched value, H = V[15:8], L = V[7:0].
- Case selection happens at acceptance, in priority order:
  - A: H==8'h00 → LI rx,L. 1 instruction.
  - B: V[15:7]==9'h1FF → LI rx,8'h00; ADDIU rx,L. 2 instructions.
  - C: L==8'h00 → LI rx,H; SLL. 2 instructions.
  - D: otherwise → LI rx,(H+V[7]) truncated to 8 bits; SLL; ADDIU rx,L. 3 instructions.
    - H+V[7] cannot overflow in D, because H=FF with V[7]=1 is already case B.
- The correction term V[7] in D compensates for the sign extension of L by ADDIU. The required result is (H+V[7])·256 + sext(L) ≡ V mod 2^16.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch value, rx and the case, then go to EMIT_LI.
  - EMIT_LI: on out_ready, go to IDLE (case A), EMIT_ADDIU (case B) or EMIT_SLL (cases C and D).
  - EMIT_SLL: on out_ready, go to IDLE (case C) or EMIT_ADDIU (case D).
  - EMIT_ADDIU: on out_ready, go to IDLE.
- out_last=1 on the final instruction of the sequence:
  - LI in case A;
  - SLL in case C;
  - ADDIU in cases B and D.
- Reset values:
  - state=IDLE;
  - req_ready=1, busy=0;
  - out_valid=0, out_last=0;
  - out_instr=16'h0000.

## Timing
- All outputs are registered. A request is accepted on the edge where req_valid && req_ready. out_valid rises 1 cycle later with the LI instruction.
- An instruction transfers on the edge where out_valid && out_ready. The next instruction is presented in the following cycle, with no bubble when out_ready is held high.
- Minimum occupancy: 1 cycle of acceptance plus N transfer cycles. req_ready reasserts the cycle after the last transfer, and back-to-back requests are then possible.
- While out_valid=1 && out_ready=0, out_instr and out_last hold stable. out_valid never drops before the transfer.
- req_ready=0 throughout a sequence. req_value and req_rx are ignored outside acceptance; changing them mid-sequence has no effect.
- Reset mid-sequence: on the next edge the FSM returns to IDLE with all outputs at their reset values. The partial sequence is abandoned, no further instructions are emitted, and req_ready=1 in the cycle after reset is released.
- rst takes priority over a simultaneous request acceptance or transfer.

## Test plan
- Case A: value=16'h0042, rx=2, out_ready=1 → one instruction 16'h6A42 with out_last=1, arriving 1 cycle after acceptance. req_ready returns the cycle after the transfer.
- Case B: value=16'hFF85, rx=0 → 16'h6800, then 16'h4885 with out_last only on 16'h4885.
- Case C: value=16'h1200, rx=1 → 16'h6912, then 16'h3120 (last).
- Case D with backpressure: value=16'h12F0, rx=3, out_ready toggled 0/1 every cycle → 16'h6B13, 16'h3360, 16'h4BF0 (last). Each word holds stable while stalled. req_ready stays 0 until the final transfer.
- Reset mid-sequence: start case D, assert rst after the LI transfer → next cycle out_valid=0, out_instr=16'h0000 and req_ready=1. A following request for 16'h0042 emits only 16'h6A42.
- Random values 0..FFFF: a reference model sums the emitted LI/SLL/ADDIU semantics and must equal the value. Instruction count is 1/2/2/3 per case A/B/C/D.
